// File: rtl/gray_step_ctrl_pkg.sv
// Shared definitions for the gray_step_ctrl slice: command opcodes, FSM states
// and the binary-to-Gray conversion used by the counter core.
package gray_step_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STEP  = 2'b10,
        OP_STOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int GRAY_MAXW = 32;

    // Width-agnostic: callers size-cast in and out of the 32-bit domain.
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_ctrl_if.sv
// Command channel of gray_step_ctrl: valid/ready handshake carrying an opcode,
// a STEP direction and a shared LOAD-value/STEP-count argument.
interface gray_step_ctrl_if
    import gray_step_ctrl_pkg::*;
#(
    parameter int AW = 8
);

    logic          cmd_valid;
    logic          cmd_ready;
    op_e           cmd_op;
    logic          cmd_dir;
    logic [AW-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_dir,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_dir,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/gray_updown_core.sv
// W-bit up/down counter with clear/load, a registered Gray copy of the count
// and a one-cycle wrap flag registered alongside the step that wrapped.
module gray_updown_core
    import gray_step_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         ret,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step_en,
    input  logic         step_dir,
    output logic [W-1:0] cnt_bin,
    output logic [W-1:0] cnt_gray,
    output logic         wrap
);

    logic [W-1:0] bin_n;
    logic         wrap_n;

    // Clear beats load beats step; the FSM never asserts more than one anyway.
    always_comb begin
        bin_n  = cnt_bin;
        wrap_n = 1'b0;
        if (clr) begin
            bin_n = '0;
        end else if (load) begin
            bin_n = load_val;
        end else if (step_en) begin
            if (step_dir) begin
                bin_n  = cnt_bin - W'(1);
                wrap_n = (cnt_bin == '0);
            end else begin
                bin_n  = cnt_bin + W'(1);
                wrap_n = (cnt_bin == '1);
            end
        end
    end

    // Gray is derived from the next binary value so both change on one edge.
    always_ff @(posedge clk) begin
        if (ret) begin
            cnt_bin  <= '0;
            cnt_gray <= '0;
            wrap     <= 1'b0;
        end else begin
            cnt_bin  <= bin_n;
            cnt_gray <= W'(bin2gray(GRAY_MAXW'(bin_n)));
            wrap     <= wrap_n;
        end
    end

endmodule

// File: rtl/gray_step_ctrl.sv
// Command-driven sequencer around gray_updown_core: CLEAR/LOAD/STEP(n)/STOP over
// a valid/ready channel, multi-cycle step bursts, done/wrap/err status pulses.
module gray_step_ctrl
    import gray_step_ctrl_pkg::*;
#(
    parameter int W  = 4,
    parameter int NW = 8
) (
    input  logic             clk,
    input  logic             ret,
    gray_step_ctrl_if.slave  cmd,
    output logic [W-1:0]     cnt_bin,
    output logic [W-1:0]     cnt_gray,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_e          state, state_n;
    logic [NW-1:0]   remaining, remaining_n;
    logic            dir, dir_n;
    logic            err_n;
    logic            accept;
    logic            core_clr, core_load, core_step;
    logic [NW-1:0]   step_count;

    assign cmd.cmd_ready = (state != S_DONE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign step_count    = cmd.cmd_arg[NW-1:0];
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (ret) begin
            state     <= S_IDLE;
            remaining <= '0;
            dir       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            dir       <= dir_n;
            err       <= err_n;
        end
    end

    // In RUN a STOP pre-empts the step on its edge; any other command is dropped.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        dir_n       = dir;
        err_n       = 1'b0;
        core_clr    = 1'b0;
        core_load   = 1'b0;
        core_step   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_CLEAR: core_clr  = 1'b1;
                        OP_LOAD:  core_load = 1'b1;
                        OP_STEP: begin
                            if (step_count == '0) begin
                                state_n = S_DONE;
                            end else begin
                                state_n     = S_RUN;
                                remaining_n = step_count;
                                dir_n       = cmd.cmd_dir;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (accept && cmd.cmd_op == OP_STOP) begin
                    state_n     = S_DONE;
                    remaining_n = '0;
                end else begin
                    core_step   = 1'b1;
                    remaining_n = remaining - NW'(1);
                    err_n       = accept;
                    if (remaining == NW'(1)) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    gray_updown_core #(
        .W(W)
    ) u_core (
        .clk      (clk),
        .ret      (ret),
        .clr      (core_clr),
        .load     (core_load),
        .load_val (cmd.cmd_arg[W-1:0]),
        .step_en  (core_step),
        .step_dir (dir),
        .cnt_bin  (cnt_bin),
        .cnt_gray (cnt_gray),
        .wrap     (wrap)
    );

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl (W=4, NW=8): directed command sequences with literal
// expectations, plus a cycle-by-cycle comparison against a behavioural model.
module tb_gray_step_ctrl;
    import gray_step_ctrl_pkg::*;

    localparam int W   = 4;
    localparam int NW  = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         ret = 1'b0;
    logic [W-1:0] cnt_bin, cnt_gray;
    logic         busy, done, wrap, err;

    int total = 0;
    int bad   = 0;

    gray_step_ctrl_if #(.AW(NW)) cmd_if ();

    gray_step_ctrl #(.W(W), .NW(NW)) dut (
        .clk      (clk),
        .ret      (ret),
        .cmd      (cmd_if),
        .cnt_bin  (cnt_bin),
        .cnt_gray (cnt_gray),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-number count, a remaining-steps tally and phase flags.
    int m_cnt = 0;
    int m_rem = 0;
    bit m_run = 0, m_done = 0, m_wrap = 0, m_err = 0, m_dir = 0, m_valid = 0;

    always @(posedge clk) begin
        int c, r;
        bit run, dn, wr, er, d, acc;
        c   = m_cnt;
        r   = m_rem;
        run = m_run;
        d   = m_dir;
        dn  = 0;
        wr  = 0;
        er  = 0;
        acc = cmd_if.cmd_valid && !m_done;
        if (ret) begin
            c   = 0;
            r   = 0;
            run = 0;
        end else if (m_done) begin
            run = 0;
        end else if (m_run) begin
            if (acc && cmd_if.cmd_op == OP_STOP) begin
                run = 0;
                r   = 0;
                dn  = 1;
            end else begin
                wr = m_dir ? (m_cnt == 0) : (m_cnt == MOD - 1);
                c  = m_dir ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
                er = acc;
                r  = r - 1;
                if (r == 0) begin
                    run = 0;
                    dn  = 1;
                end
            end
        end else if (acc) begin
            case (cmd_if.cmd_op)
                OP_CLEAR: c = 0;
                OP_LOAD:  c = int'(cmd_if.cmd_arg) % MOD;
                OP_STEP: begin
                    if (cmd_if.cmd_arg == 0) begin
                        dn = 1;
                    end else begin
                        run = 1;
                        r   = int'(cmd_if.cmd_arg);
                        d   = cmd_if.cmd_dir;
                    end
                end
                default: ;
            endcase
        end
        m_cnt   <= c;
        m_rem   <= r;
        m_run   <= run;
        m_dir   <= d;
        m_done  <= dn;
        m_wrap  <= wr;
        m_err   <= er;
        m_valid <= m_valid | ret;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_bin",   int'(cnt_bin),  m_cnt);
            checkOutput("model_gray",  int'(cnt_gray), (m_cnt ^ (m_cnt >> 1)) % MOD);
            checkOutput("model_busy",  int'(busy),     int'(m_run));
            checkOutput("model_done",  int'(done),     int'(m_done));
            checkOutput("model_wrap",  int'(wrap),     int'(m_wrap));
            checkOutput("model_err",   int'(err),      int'(m_err));
            checkOutput("model_ready", int'(cmd_if.cmd_ready), int'(!m_done));
        end
    end

    // Presents one command and returns 1 ns after the edge that accepted it.
    task automatic applyStimulus(input op_e op, input logic dir, input logic [NW-1:0] arg,
                                 output int stalls);
        bit accepted, w;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_arg   = arg;
        stalls   = 0;
        accepted = 0;
        for (int t = 0; t < 16 && !accepted; t++) begin
            w = cmd_if.cmd_ready;
            @(posedge clk);
            if (w) accepted = 1;
            else begin
                stalls++;
                @(negedge clk);
            end
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] grayTbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                   4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                   4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st, wraps, busyCycles;
        int downBin[3]  = '{1, 0, 15};
        int downGray[3] = '{1, 0, 8};
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_CLEAR;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_arg   = '0;

        // Reset
        @(negedge clk);
        ret = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_bin",   int'(cnt_bin),  0);
        checkOutput("rst_gray",  int'(cnt_gray), 0);
        checkOutput("rst_busy",  int'(busy),     0);
        checkOutput("rst_done",  int'(done),     0);
        checkOutput("rst_ready", int'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        ret = 1'b0;

        // Full up sweep of 16 steps with a single wrap
        applyStimulus(OP_STEP, 1'b0, 8'd16, st);
        wraps = 0;
        for (int i = 1; i <= 16; i++) begin
            stepEdge();
            checkOutput("up16_gray", int'(cnt_gray), int'(grayTbl[i % 16]));
            wraps += int'(wrap);
        end
        checkOutput("up16_wraps", wraps, 1);
        checkOutput("up16_done",  int'(done), 1);
        checkOutput("up16_busy",  int'(busy), 0);

        // LOAD 2 then three down steps through zero
        applyStimulus(OP_LOAD, 1'b0, 8'd2, st);
        checkOutput("load2_bin", int'(cnt_bin), 2);
        applyStimulus(OP_STEP, 1'b1, 8'd3, st);
        busyCycles = int'(busy);
        for (int i = 0; i < 3; i++) begin
            stepEdge();
            checkOutput("down3_bin",  int'(cnt_bin),  downBin[i]);
            checkOutput("down3_gray", int'(cnt_gray), downGray[i]);
            checkOutput("down3_wrap", int'(wrap),     (i == 2) ? 1 : 0);
            busyCycles += int'(busy);
        end
        repeat (2) begin
            stepEdge();
            busyCycles += int'(busy);
        end
        checkOutput("down3_busy_cycles", busyCycles, 3);

        // STOP on the fourth RUN cycle of a 10-step burst
        applyStimulus(OP_CLEAR, 1'b0, 8'd0, st);
        applyStimulus(OP_STEP, 1'b0, 8'd10, st);
        repeat (3) stepEdge();
        applyStimulus(OP_STOP, 1'b0, 8'd0, st);
        checkOutput("stop_bin",  int'(cnt_bin), 3);
        checkOutput("stop_done", int'(done),    1);
        checkOutput("stop_busy", int'(busy),    0);
        stepEdge();
        checkOutput("stop_bin_hold", int'(cnt_bin), 3);

        // STEP 0 goes straight to DONE; a LOAD stalls through it
        applyStimulus(OP_STEP, 1'b0, 8'd0, st);
        checkOutput("step0_done",  int'(done),    1);
        checkOutput("step0_ready", int'(cmd_if.cmd_ready), 0);
        checkOutput("step0_bin",   int'(cnt_bin), 3);
        applyStimulus(OP_LOAD, 1'b0, 8'd9, st);
        checkOutput("load_stalls", st, 1);
        checkOutput("load9_bin",   int'(cnt_bin), 9);

        // LOAD mid-RUN is dropped with an err pulse
        applyStimulus(OP_CLEAR, 1'b0, 8'd0, st);
        applyStimulus(OP_STEP, 1'b0, 8'd5, st);
        stepEdge();
        applyStimulus(OP_LOAD, 1'b0, 8'd12, st);
        checkOutput("runload_err",  int'(err),     1);
        checkOutput("runload_bin",  int'(cnt_bin), 2);
        stepEdge();
        checkOutput("runload_err_clr", int'(err),  0);
        repeat (2) stepEdge();
        checkOutput("runload_final", int'(cnt_bin), 5);
        checkOutput("runload_done",  int'(done),    1);

        // Reset mid-RUN at count 7, then a fresh down burst
        applyStimulus(OP_CLEAR, 1'b0, 8'd0, st);
        applyStimulus(OP_STEP, 1'b0, 8'd20, st);
        repeat (7) stepEdge();
        checkOutput("midrst_pre_bin", int'(cnt_bin), 7);
        @(negedge clk);
        ret = 1'b1;
        stepEdge();
        checkOutput("midrst_bin",   int'(cnt_bin),  0);
        checkOutput("midrst_gray",  int'(cnt_gray), 0);
        checkOutput("midrst_busy",  int'(busy),     0);
        checkOutput("midrst_flags", int'({done, wrap, err}), 0);
        checkOutput("midrst_ready", int'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        ret = 1'b0;
        applyStimulus(OP_STEP, 1'b1, 8'd2, st);
        stepEdge();
        checkOutput("fresh_bin1", int'(cnt_bin), 15);
        checkOutput("fresh_wrap", int'(wrap),    1);
        stepEdge();
        checkOutput("fresh_bin2", int'(cnt_bin),  14);
        checkOutput("fresh_gray", int'(cnt_gray), 9);
        checkOutput("fresh_done", int'(done),     1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
